// File: rtl/imem_responder_if.sv
// Fetch-side handshake bundle between the fetch unit (master) and the
// instruction-memory responder (slave).
interface imem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one word fetch at a time, waits
// WAIT_CYCLES cycles, then returns the addressed word (or an error) and holds
// it until the fetch unit takes it. The word array is filled via a side port.
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   imem_responder_if.slave                bus,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  logic [31:0]                    load_data
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, next_state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] cap_addr;
   logic        accept;
   logic        enter_resp;
   logic        cap_err;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_data_q;
   logic [31:0] mem [DEPTH_WORDS];

   // Next-state decode and request-accept strobe.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               accept     = 1'b1;
               next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt <= 4'd1) next_state = S_RESP;
         end
         S_RESP: begin
            if (bus.resp_ready) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // With zero wait states RESP is entered on the accept edge itself, so the
   // capture must use the live request address rather than the latched one.
   assign enter_resp = (next_state == S_RESP) && (state != S_RESP);
   assign cap_addr   = (state == S_IDLE) ? bus.req_addr : addr_q;
   assign cap_err    = (cap_addr[1:0] != 2'b00) ||
                       ({2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Registered handshake outputs, wait counter, address latch and response capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         addr_q       <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         req_ready_q  <= (next_state == S_IDLE);
         resp_valid_q <= (next_state == S_RESP);
         if (accept) begin
            addr_q <= bus.req_addr;
            cnt    <= 4'(WAIT_CYCLES);
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_err_q  <= cap_err;
            resp_data_q <= cap_err ? '0 : mem[cap_addr[2 +: AW]];
         end else if ((state == S_RESP) && (next_state == S_IDLE)) begin
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
         end
      end
   end

   // Preload write port; storage has no reset so contents survive reset.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (0, 1 and 3 wait states) share
// clock, reset, preload port and request fields; sel picks the active one.
module tb_imem_responder;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      int          wc;        // which instance (its wait-state count)
      logic [31:0] addr;
      logic [31:0] exp_data;
      logic        exp_err;
      int          hold;      // cycles to hold resp_ready low in RESP
      int          ld_at;     // cycle after accept to pulse a preload (-1 none)
      logic [7:0]  ld_idx;
      logic [31:0] ld_data;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        resp_ready;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;
   int          sel;

   logic        obs_ready, obs_valid, obs_err;
   logic [31:0] obs_data;

   int errors = 0;
   int checks = 0;
   exp_t sb[$];
   vec_t vecs[16];

   always #5 clk = ~clk;

   imem_responder_if bus_w0 ();
   imem_responder_if bus_w1 ();
   imem_responder_if bus_w3 ();

   assign bus_w0.req_valid  = req_valid && (sel == 0);
   assign bus_w1.req_valid  = req_valid && (sel == 1);
   assign bus_w3.req_valid  = req_valid && (sel == 3);
   assign bus_w0.req_addr   = req_addr;
   assign bus_w1.req_addr   = req_addr;
   assign bus_w3.req_addr   = req_addr;
   assign bus_w0.resp_ready = resp_ready;
   assign bus_w1.resp_ready = resp_ready;
   assign bus_w3.resp_ready = resp_ready;

   imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .reset(reset), .bus(bus_w0),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
   imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .reset(reset), .bus(bus_w1),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
   imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .reset(reset), .bus(bus_w3),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   // Observed outputs of the currently selected instance.
   always_comb begin
      obs_ready = bus_w1.req_ready;
      obs_valid = bus_w1.resp_valid;
      obs_data  = bus_w1.resp_data;
      obs_err   = bus_w1.resp_err;
      if (sel == 0) begin
         obs_ready = bus_w0.req_ready;
         obs_valid = bus_w0.resp_valid;
         obs_data  = bus_w0.resp_data;
         obs_err   = bus_w0.resp_err;
      end else if (sel == 3) begin
         obs_ready = bus_w3.req_ready;
         obs_valid = bus_w3.resp_valid;
         obs_data  = bus_w3.resp_data;
         obs_err   = bus_w3.resp_err;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", name, got, exp, sel, $time);
      end
   endtask

   // Scoreboard: a response handshake seen here completes on the next edge.
   always @(negedge clk) begin
      if (!reset && obs_valid && resp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(obs_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_data", obs_data, e.data);
            chk("resp_err", 32'(obs_err), 32'(e.err));
         end
      end
   end

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = idx; load_data = data;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   // Present a request and return 1 time unit after the accept edge.
   task automatic issue(input logic [31:0] addr);
      int n;
      bit got;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = addr;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (obs_ready) got = 1;
         else begin @(posedge clk); #1; n++; end
      end
      if (!got) chk("accept_timeout", 32'(obs_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
   endtask

   task automatic do_fetch(input vec_t v);
      int  cyc;
      int  hold_left;
      bit  seen, done;
      exp_t e;
      sel = v.wc;
      e.data = v.exp_data;
      e.err  = v.exp_err;
      sb.push_back(e);
      resp_ready = (v.hold == 0);
      issue(v.addr);
      cyc = 0; seen = 0; done = 0; hold_left = v.hold;
      while (!done && cyc < 40) begin
         load_en   = (v.ld_at >= 0) && (cyc == v.ld_at);
         load_addr = v.ld_idx;
         load_data = v.ld_data;
         if (v.hold != 0) resp_ready = seen && (hold_left == 0);
         @(negedge clk);
         if (obs_valid) begin
            if (!seen) begin
               seen = 1;
               chk("latency", 32'(cyc + 1), 32'(v.wc + 1));
            end else begin
               chk("hold_data", obs_data, v.exp_data);
               chk("hold_err", 32'(obs_err), 32'(v.exp_err));
               chk("hold_ready", 32'(obs_ready), 32'd0);
            end
            if (resp_ready) done = 1;
            else if (hold_left > 0) hold_left--;
         end else begin
            chk("wait_ready", 32'(obs_ready), 32'd0);
         end
         @(posedge clk); #1;
         cyc++;
      end
      load_en    = 1'b0;
      resp_ready = 1'b0;
      if (!done) begin
         chk("resp_timeout", 32'(obs_valid), 32'd1);
         void'(sb.pop_back());
      end
      @(negedge clk);
      chk("idle_valid", 32'(obs_valid), 32'd0);
      chk("idle_ready", 32'(obs_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int n;
      reset = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0; sel = 1;

      vecs[0]  = '{1, 32'h0000_0000, 32'h0000_0013, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[1]  = '{1, 32'h0000_0004, 32'h0010_0093, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[2]  = '{1, 32'h0000_0008, 32'h0020_0113, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[3]  = '{1, 32'h0000_000C, 32'h0020_81B3, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[4]  = '{1, 32'h0000_0002, 32'h0000_0000, 1'b1, 0, -1, 8'd0, 32'h0};
      vecs[5]  = '{1, 32'h0000_0400, 32'h0000_0000, 1'b1, 0, -1, 8'd0, 32'h0};
      vecs[6]  = '{1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[7]  = '{1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 0, -1, 8'd0, 32'h0};
      vecs[8]  = '{1, 32'h0000_0008, 32'h0020_0113, 1'b0, 5,  2, 8'd2, 32'h5555_5555};
      vecs[9]  = '{3, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 0,  1, 8'd4, 32'hDEAD_BEEF};
      vecs[10] = '{1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 0,  0, 8'd4, 32'h1234_5678};
      vecs[11] = '{1, 32'h0000_0010, 32'h1234_5678, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[12] = '{0, 32'h0000_0004, 32'h0010_0093, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[13] = '{0, 32'h0000_0008, 32'h5555_5555, 1'b0, 0, -1, 8'd0, 32'h0};
      vecs[14] = '{0, 32'h0000_0006, 32'h0000_0000, 1'b1, 0, -1, 8'd0, 32'h0};
      vecs[15] = '{3, 32'h0000_0000, 32'h0000_0013, 1'b0, 2, -1, 8'd0, 32'h0};

      // Reset state, asserted before any clock edge.
      #1 reset = 1'b1;
      #2;
      chk("rst_req_ready", 32'(obs_ready), 32'd0);
      chk("rst_resp_valid", 32'(obs_valid), 32'd0);
      chk("rst_resp_data", obs_data, 32'd0);
      chk("rst_resp_err", 32'(obs_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("ready_after_release", 32'(obs_ready), 32'd0);
      @(negedge clk);
      chk("ready_first_cycle", 32'(obs_ready), 32'd1);

      preload(8'd0, 32'h0000_0013);
      preload(8'd1, 32'h0010_0093);
      preload(8'd2, 32'h0020_0113);
      preload(8'd3, 32'h0020_81B3);
      preload(8'd4, 32'h1111_1111);
      preload(8'd255, 32'hCAFE_F00D);

      for (int i = 0; i < 16; i++) do_fetch(vecs[i]);

      // Reset during WAIT: nothing comes back, later fetches still see the array.
      sel = 3;
      resp_ready = 1'b1;
      issue(32'h0000_0000);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("wait_rst_valid", 32'(obs_valid), 32'd0);
      chk("wait_rst_ready", 32'(obs_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("wait_rst_no_resp", 32'(obs_valid), 32'd0);
      end
      resp_ready = 1'b0;

      // Reset while a response is held: outputs drop without waiting for an edge.
      sel = 1;
      issue(32'h0000_0004);
      n = 0;
      while (!obs_valid && n < 20) begin @(negedge clk); n++; end
      chk("resp_rst_pre_data", obs_data, 32'h0010_0093);
      #2 reset = 1'b1;
      #1;
      chk("resp_rst_valid", 32'(obs_valid), 32'd0);
      chk("resp_rst_data", obs_data, 32'd0);
      chk("resp_rst_ready", 32'(obs_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("resp_rst_ready_back", 32'(obs_ready), 32'd1);

      v = '{1, 32'h0000_0000, 32'h0000_0013, 1'b0, 0, -1, 8'd0, 32'h0};
      do_fetch(v);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
